// File: rtl/count_sequencer.sv
// Job controller for an external N-bit load/enable/terminal-compare up-counter.
// Runs cfg_reps repetitions of cfg_start..cfg_bound behind a start/busy/done handshake.
module count_sequencer #(
  parameter int N = 6,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         tick,
  input  logic [N-1:0] cfg_start,
  input  logic [N-1:0] cfg_bound,
  input  logic [R-1:0] cfg_reps,
  input  logic         cnt_co,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic [N-1:0] cnt_par_load,
  output logic [N-1:0] cnt_upper_bound,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic         err,
  output logic [R-1:0] rep_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [N-1:0] ZERO_N = {N{1'b0}};
  localparam logic [R-1:0] ZERO_R = {R{1'b0}};
  localparam logic [R-1:0] ONE_R  = {{(R-1){1'b0}}, 1'b1};

  state_t       state_r;
  logic         gap_r;
  logic         busy_r;
  logic         done_r;
  logic         aborted_r;
  logic         err_r;
  logic [R-1:0] rep_idx_r;
  logic [R-1:0] reps_r;
  logic [N-1:0] start_r;
  logic [N-1:0] bound_r;

  logic         cfg_bad_s;
  logic         rep_end_s;
  logic         last_rep_s;

  assign cfg_bad_s  = (cfg_start > cfg_bound) || (cfg_reps == ZERO_R);
  assign rep_end_s  = tick && cnt_co;
  assign last_rep_s = (rep_idx_r == (reps_r - ONE_R));

  assign cnt_par_load    = start_r;
  assign cnt_upper_bound = bound_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign aborted         = aborted_r;
  assign err             = err_r;
  assign rep_idx         = rep_idx_r;

  // Counter strobes; abort suppresses both in the cycle it is seen, and
  // the terminal value is never stepped past because cnt_co gates the enable.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_r)
      LOAD: begin
        if (!gap_r && !abort) begin
          cnt_load = 1'b1;
        end else begin
          cnt_load = 1'b0;
        end
      end
      RUN: begin
        cnt_en = tick & ~cnt_co & ~abort;
      end
      default: begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered status outputs and latched job configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      gap_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      err_r     <= 1'b0;
      rep_idx_r <= ZERO_R;
      reps_r    <= ZERO_R;
      start_r   <= ZERO_N;
      bound_r   <= ZERO_N;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            start_r   <= cfg_start;
            bound_r   <= cfg_bound;
            reps_r    <= cfg_reps;
            rep_idx_r <= ZERO_R;
            gap_r     <= 1'b0;
            if (cfg_bad_s) begin
              err_r   <= 1'b1;
              state_r <= IDLE;
            end else begin
              err_r   <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= LOAD;
            end
          end
        end
        // A reload spends one dead cycle (gap_r) before the load strobe.
        LOAD: begin
          if (abort) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
            gap_r     <= 1'b0;
          end else if (gap_r) begin
            gap_r <= 1'b0;
          end else begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
          end else if (rep_end_s) begin
            if (last_rep_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              rep_idx_r <= rep_idx_r + ONE_R;
              gap_r     <= 1'b1;
              state_r   <= LOAD;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          gap_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
